hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Sequencing controller for the CPU's iterative unsigned divider and the HI/LO register pair. It accepts DIV and DIVU requests from the execute stage and converts signed operands to magnitudes. It issues a one-cycle start to the divider, waits a fixed latency, applies the sign correction, and writes HI (remainder) and LO (quotient). It stalls the pipeline while a division is in flight and also services MTHI/MTLO writes.

## Interface
- DIV_LAT, 1: cycles after the ISSUE cycle until div_q/div_r are valid. Must be ≥1.
- clock  in  1  all state updates on the rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  DIV/DIVU request; sampled only in IDLE
- op_signed  in  1  1 = DIV (two's complement), 0 = DIVU
- rs_val  in  32  dividend
- rt_val  in  32  divisor
- mthi  in  1  write wdata to HI (IDLE only)
- mtlo  in  1  write wdata to LO (IDLE only)
- wdata  in  32  MTHI/MTLO data
- hi  out  32  HI register (remainder)
- lo  out  32  LO register (quotient)
- stall  out  1  pipeline hold
- done  out  1  one-cycle pulse when HI/LO take a division result
- div_by_zero  out  1  one-cycle pulse coincident with done when rt_val was 0
- div_start  out  1  start strobe to the divider
- div_dividend  out  32  unsigned dividend magnitude
- div_divisor  out  32  unsigned divisor magnitude
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder

## Operation
- States: IDLE, ISSUE, WAIT, FIX.
- IDLE with op_valid and rt_val≠0:
  - latch neg_q = op_signed & (rs_val[31]^rt_val[31]) and neg_r = op_signed & rs_val[31];
  - latch the magnitudes into div_dividend/div_divisor (negated if op_signed and bit 31 set; 0x80000000 stays 0x80000000);
  - go to ISSUE.
- IDLE with op_valid and rt_val=0: write hi=rs_val and lo=0xFFFFFFFF at that edge; no div_start; done=div_by_zero=1 next cycle; stay IDLE.
- ISSUE: div_start=1 for exactly this cycle; load the counter with DIV_LAT; go to WAIT.
- WAIT: decrement the counter each cycle. On the last cycle (counter=1), capture div_q/div_r into internal registers and go to FIX.
- FIX: lo = neg_q ? −q : q and hi = neg_r ? −r : r, 32-bit wrap. Go to IDLE. done=1 in the following cycle.
- Remainder sign follows the dividend. 0x80000000 / 0xFFFFFFFF signed yields lo=0x80000000, hi=0, with no exception.
- div_dividend and div_divisor hold stable from ISSUE through FIX.
- mthi/mtlo in IDLE write HI/LO at that edge. If op_valid is also high, the write happens and the division starts; the division result later overwrites the register.
- op_valid, mthi and mtlo are ignored while state≠IDLE.
- Reset at any point, including mid-WAIT:
  - state returns to IDLE;
  - hi=lo=0;
  - stall, done, div_by_zero and div_start all 0;
  - the counter and latched operands are cleared;
  - any in-flight result is discarded.

## Timing
- stall is combinational: (state≠IDLE) | (state==IDLE & op_valid).
- Normal division:
  - cycle 0: accept, stall=1;
  - cycle 1: ISSUE;
  - cycles 2..DIV_LAT+1: WAIT;
  - cycle DIV_LAT+2: FIX;
  - cycle DIV_LAT+3: IDLE, hi/lo updated, done=1, stall=0.
  - stall is high for DIV_LAT+3 cycles.
- Divide-by-zero: stall for 1 cycle; done and div_by_zero high in cycle 1.
- Back-to-back: a new op_valid is accepted in the same cycle done is high.
- hi and lo are registered outputs and are never combinational from inputs.
- Reset values: hi=0, lo=0, stall=0 (absent op_valid), done=0, div_by_zero=0, div_start=0, div_dividend=0, div_divisor=0.

## Test plan
- DIVU 100/7, DIV_LAT=1: div_start high in cycle 1 only; stall high for 4 cycles; then lo=14, hi=2, done pulse.
- DIV −7/2 (0xFFFFFFF9, 2): div_dividend=7 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 7/−2 → lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, no div_by_zero.
- DIVU 0x1234/0 → no div_start; hi=0x1234, lo=0xFFFFFFFF; done and div_by_zero high one cycle after accept.
- Interference:
  - mthi=1 with wdata=0xAAAA in IDLE → hi=0xAAAA;
  - mtlo pulse and a second op_valid during WAIT → both ignored, and the first result is written unchanged.
- Assert reset in the second WAIT cycle with DIV_LAT=4 → next cycle IDLE, hi=lo=0, stall=0, no done. A fresh DIVU 9/3 then gives lo=3, hi=0.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequences the iterative unsigned divider for DIV/DIVU,
// applies the sign correction to its result, owns the HI/LO register pair
// and services MTHI/MTLO writes while the pipeline is not dividing.
module hilo_div_ctrl #(
  parameter int DIV_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_signed,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        done,
  output logic        div_by_zero,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  // Counter wide enough to hold DIV_LAT; never narrower than one bit.
  localparam int CW = (DIV_LAT < 2) ? 1 : $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIX   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [31:0]   dividend_q, dividend_d;
  logic [31:0]   divisor_q, divisor_d;
  logic [31:0]   quo_cap_q, quo_cap_d;
  logic [31:0]   rem_cap_q, rem_cap_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  // Unsigned magnitude of an operand. For signed operands with bit 31 set
  // this is the two's complement negation; 0x80000000 maps to itself, which
  // is exactly the magnitude the unsigned divider needs.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      return (~v) + 32'd1;
    end
    return v;
  endfunction

  // Next-state logic: accept requests and MTHI/MTLO in IDLE, issue the start
  // strobe, count down the divider latency, then sign-correct and write HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quo_cap_d  = quo_cap_q;
    rem_cap_d  = rem_cap_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mthi) begin
          hi_d = wdata;
        end
        if (mtlo) begin
          lo_d = wdata;
        end
        if (op_valid) begin
          if (rt_val == 32'd0) begin
            // Divide by zero finishes on the spot without touching the divider.
            hi_d   = rs_val;
            lo_d   = 32'hFFFF_FFFF;
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            neg_quo_d  = op_signed & (rs_val[31] ^ rt_val[31]);
            neg_rem_d  = op_signed & rs_val[31];
            dividend_d = magnitude(rs_val, op_signed);
            divisor_d  = magnitude(rt_val, op_signed);
            state_d    = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          // Divider outputs are valid in this cycle only; keep a private copy.
          quo_cap_d = div_q;
          rem_cap_d = div_r;
          cnt_d     = '0;
          state_d   = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_FIX: begin
        lo_d    = neg_quo_q ? (32'd0 - quo_cap_q) : quo_cap_q;
        hi_d    = neg_rem_q ? (32'd0 - rem_cap_q) : rem_cap_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards anything in flight and clears HI/LO.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      quo_cap_q  <= 32'd0;
      rem_cap_q  <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quo_cap_q  <= quo_cap_d;
      rem_cap_q  <= rem_cap_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  // The pipeline holds while dividing and in the cycle a request is offered.
  assign stall        = (state_q != S_IDLE) | op_valid;
  assign div_start    = (state_q == S_ISSUE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign done         = done_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Testbench for hilo_div_ctrl: two instances (DIV_LAT=1 and DIV_LAT=4), a
// behavioural divider per instance, and a transaction-level timeline model
// checked against the DUT outputs on every cycle.
module tb_hilo_div_ctrl;

  localparam int NI = 2;

  logic clock = 1'b0;
  logic reset;

  logic        op_valid [NI];
  logic        op_signed[NI];
  logic [31:0] rs_val   [NI];
  logic [31:0] rt_val   [NI];
  logic        mthi     [NI];
  logic        mtlo     [NI];
  logic [31:0] wdata    [NI];
  logic [31:0] hi       [NI];
  logic [31:0] lo       [NI];
  logic        stall    [NI];
  logic        done     [NI];
  logic        div_by_zero[NI];
  logic        div_start[NI];
  logic [31:0] div_dividend[NI];
  logic [31:0] div_divisor [NI];

  // Divider model state
  int          dlat     [NI];
  logic [31:0] junk_q   [NI];
  logic [31:0] junk_r   [NI];
  logic        start_seen[NI];

  // Reference model state
  logic [31:0] exp_hi[NI], exp_lo[NI], exp_dd[NI], exp_ds[NI];
  logic [31:0] pend_hi[NI], pend_lo[NI];
  bit          busy[NI];
  longint      acc_cyc[NI], done_at[NI], dbz_at[NI];
  longint      cyc = 0;
  bit          model_ok = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [31:0] dq, dr;
      // The divider presents a correct answer only in its valid cycle.
      assign dq = (dlat[g] == 1 && div_divisor[g] != 32'd0) ? div_dividend[g] / div_divisor[g] : junk_q[g];
      assign dr = (dlat[g] == 1 && div_divisor[g] != 32'd0) ? div_dividend[g] % div_divisor[g] : junk_r[g];

      hilo_div_ctrl #(.DIV_LAT((g == 0) ? 1 : 4)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid[g]),
        .op_signed   (op_signed[g]),
        .rs_val      (rs_val[g]),
        .rt_val      (rt_val[g]),
        .mthi        (mthi[g]),
        .mtlo        (mtlo[g]),
        .wdata       (wdata[g]),
        .hi          (hi[g]),
        .lo          (lo[g]),
        .stall       (stall[g]),
        .done        (done[g]),
        .div_by_zero (div_by_zero[g]),
        .div_start   (div_start[g]),
        .div_dividend(div_dividend[g]),
        .div_divisor (div_divisor[g]),
        .div_q       (dq),
        .div_r       (dr)
      );
    end
  endgenerate

  // Arithmetic reference for quotient/remainder (truncating, remainder follows dividend).
  function automatic void div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint x, y;
    if (sgn) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = {32'd0, a};
      y = {32'd0, b};
    end
    q = 32'(x / y);
    r = 32'(x % y);
  endfunction

  function automatic logic [31:0] mag_ref(input bit sgn, input logic [31:0] a);
    longint x;
    if (sgn) x = $signed(a);
    else     x = {32'd0, a};
    if (x < 0) x = -x;
    return 32'(x);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d cyc=%0d got=%h want=%h", name, i, cyc, got, want);
    end
  endtask

  // Divider model: count down from the start strobe, refresh junk every cycle.
  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) dlat[i] <= 0;
      else if (start_seen[i]) dlat[i] <= lat_of(i);
      else if (dlat[i] > 0) dlat[i] <= dlat[i] - 1;
      junk_q[i] <= $urandom;
      junk_r[i] <= $urandom;
    end
  end

  // Timeline model: a division accepted at cycle t starts at t+1, writes at
  // the end of t+L+2 and reports done in t+L+3.
  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      int L;
      L = lat_of(i);
      if (reset) begin
        exp_hi[i] = 32'd0; exp_lo[i] = 32'd0;
        exp_dd[i] = 32'd0; exp_ds[i] = 32'd0;
        busy[i] = 1'b0; done_at[i] = -1; dbz_at[i] = -1;
      end else if (model_ok) begin
        if (busy[i]) begin
          if (cyc == acc_cyc[i] + L + 2) begin
            exp_hi[i] = pend_hi[i];
            exp_lo[i] = pend_lo[i];
            done_at[i] = cyc + 1;
            busy[i] = 1'b0;
          end
        end else begin
          if (mthi[i]) exp_hi[i] = wdata[i];
          if (mtlo[i]) exp_lo[i] = wdata[i];
          if (op_valid[i]) begin
            if (rt_val[i] == 32'd0) begin
              exp_hi[i] = rs_val[i];
              exp_lo[i] = 32'hFFFF_FFFF;
              done_at[i] = cyc + 1;
              dbz_at[i]  = cyc + 1;
            end else begin
              busy[i] = 1'b1;
              acc_cyc[i] = cyc;
              div_ref(op_signed[i], rs_val[i], rt_val[i], pend_lo[i], pend_hi[i]);
              exp_dd[i] = mag_ref(op_signed[i], rs_val[i]);
              exp_ds[i] = mag_ref(op_signed[i], rt_val[i]);
            end
          end
        end
      end
    end
    if (reset) model_ok = 1'b1;
    cyc = cyc + 1;
  end

  // Compare process: every output of every instance, every cycle after reset.
  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      start_seen[i] = div_start[i];
      if (model_ok) begin
        checkOutput("hi", i, hi[i], exp_hi[i]);
        checkOutput("lo", i, lo[i], exp_lo[i]);
        checkOutput("div_dividend", i, div_dividend[i], exp_dd[i]);
        checkOutput("div_divisor", i, div_divisor[i], exp_ds[i]);
        checkOutput("stall", i, 32'(stall[i]), 32'(busy[i] || op_valid[i]));
        checkOutput("done", i, 32'(done[i]), 32'(done_at[i] == cyc));
        checkOutput("div_by_zero", i, 32'(div_by_zero[i]), 32'(dbz_at[i] == cyc));
        checkOutput("div_start", i, 32'(div_start[i]), 32'(busy[i] && cyc == acc_cyc[i] + 1));
      end
    end
  end

  // Wait (bounded) for done on instance i, counting stall and start cycles.
  task automatic waitDone(input int i, inout int stall_cnt, inout int start_cnt,
                          output bit got_done, output bit got_dbz);
    got_done = 1'b0;
    got_dbz  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (stall[i]) stall_cnt++;
      if (div_start[i]) start_cnt++;
      if (done[i]) begin
        got_done = 1'b1;
        got_dbz  = div_by_zero[i];
        break;
      end
      @(posedge clock); #2;
      op_valid[i] = 1'b0;
    end
    if (!got_done) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL timeout inst%0d got=no_done want=done", i);
    end
  endtask

  // Offer one division request and wait for its completion.
  task automatic applyStimulus(input int i, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               output int stall_cnt, output int start_cnt, output bit got_dbz);
    bit got_done;
    @(posedge clock); #2;
    op_valid[i] = 1'b1; op_signed[i] = sgn; rs_val[i] = a; rt_val[i] = b;
    stall_cnt = 0;
    start_cnt = 0;
    waitDone(i, stall_cnt, start_cnt, got_done, got_dbz);
    op_valid[i] = 1'b0;
  endtask

  task automatic clearInputs(input int i);
    op_valid[i] = 1'b0; op_signed[i] = 1'b0; rs_val[i] = 32'd0; rt_val[i] = 32'd0;
    mthi[i] = 1'b0; mtlo[i] = 1'b0; wdata[i] = 32'd0;
  endtask

  initial begin
    int sc, stc, ndone;
    bit dz, gd;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) clearInputs(i);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    @(negedge clock);
    checkOutput("rst_hi", 0, hi[0], 32'd0);
    checkOutput("rst_lo", 0, lo[0], 32'd0);
    checkOutput("rst_stall", 0, 32'(stall[0]), 32'd0);
    checkOutput("rst_dd", 0, div_dividend[0], 32'd0);

    // DIV_LAT=1 directed cases
    applyStimulus(0, 1'b0, 32'd100, 32'd7, sc, stc, dz);
    checkOutput("divu100_7_lo", 0, lo[0], 32'd14);
    checkOutput("divu100_7_hi", 0, hi[0], 32'd2);
    checkOutput("divu100_7_stall_cycles", 0, 32'(sc), 32'd4);
    checkOutput("divu100_7_start_cycles", 0, 32'(stc), 32'd1);

    applyStimulus(0, 1'b1, 32'hFFFF_FFF9, 32'd2, sc, stc, dz);
    checkOutput("div_m7_2_lo", 0, lo[0], 32'hFFFF_FFFD);
    checkOutput("div_m7_2_hi", 0, hi[0], 32'hFFFF_FFFF);
    checkOutput("div_m7_2_dd", 0, div_dividend[0], 32'd7);

    applyStimulus(0, 1'b1, 32'd7, 32'hFFFF_FFFE, sc, stc, dz);
    checkOutput("div_7_m2_lo", 0, lo[0], 32'hFFFF_FFFD);
    checkOutput("div_7_m2_hi", 0, hi[0], 32'd1);

    applyStimulus(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, sc, stc, dz);
    checkOutput("div_min_m1_lo", 0, lo[0], 32'h8000_0000);
    checkOutput("div_min_m1_hi", 0, hi[0], 32'd0);
    checkOutput("div_min_m1_dbz", 0, 32'(dz), 32'd0);

    applyStimulus(0, 1'b0, 32'h1234, 32'd0, sc, stc, dz);
    checkOutput("dbz_hi", 0, hi[0], 32'h1234);
    checkOutput("dbz_lo", 0, lo[0], 32'hFFFF_FFFF);
    checkOutput("dbz_flag", 0, 32'(dz), 32'd1);
    checkOutput("dbz_stall_cycles", 0, 32'(sc), 32'd1);
    checkOutput("dbz_start_cycles", 0, 32'(stc), 32'd0);

    @(posedge clock); #2;
    mthi[0] = 1'b1; wdata[0] = 32'hAAAA;
    @(posedge clock); #2;
    mthi[0] = 1'b0;
    @(negedge clock);
    checkOutput("mthi_hi", 0, hi[0], 32'hAAAA);

    // DIV_LAT=4: interference during WAIT is ignored
    @(posedge clock); #2;
    op_valid[1] = 1'b1; op_signed[1] = 1'b0; rs_val[1] = 32'd1000; rt_val[1] = 32'd10;
    @(posedge clock); #2;
    op_valid[1] = 1'b0;
    @(posedge clock); #2;
    @(posedge clock); #2;
    mtlo[1] = 1'b1; wdata[1] = 32'h5555; op_valid[1] = 1'b1; rs_val[1] = 32'd77; rt_val[1] = 32'd0;
    @(posedge clock); #2;
    clearInputs(1);
    sc = 0; stc = 0;
    waitDone(1, sc, stc, gd, dz);
    checkOutput("interf_lo", 1, lo[1], 32'd100);
    checkOutput("interf_hi", 1, hi[1], 32'd0);
    checkOutput("interf_dbz", 1, 32'(dz), 32'd0);

    // DIV_LAT=4: reset in the second WAIT cycle
    @(posedge clock); #2;
    op_valid[1] = 1'b1; op_signed[1] = 1'b0; rs_val[1] = 32'd500; rt_val[1] = 32'd3;
    @(posedge clock); #2;
    op_valid[1] = 1'b0;
    @(posedge clock); #2;
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midrst_hi", 1, hi[1], 32'd0);
    checkOutput("midrst_lo", 1, lo[1], 32'd0);
    checkOutput("midrst_stall", 1, 32'(stall[1]), 32'd0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done[1]) ndone++;
      @(negedge clock);
    end
    checkOutput("midrst_no_done", 1, 32'(ndone), 32'd0);

    applyStimulus(1, 1'b0, 32'd9, 32'd3, sc, stc, dz);
    checkOutput("divu9_3_lo", 1, lo[1], 32'd3);
    checkOutput("divu9_3_hi", 1, hi[1], 32'd0);
    checkOutput("divu9_3_stall_cycles", 1, 32'(sc), 32'd7);

    // Randomized traffic on each instance, checked by the compare process
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 300; k++) begin
        @(posedge clock); #2;
        reset = ($urandom_range(0, 199) == 0);
        op_valid[i]  = ($urandom_range(0, 2) == 0);
        op_signed[i] = $urandom_range(0, 1);
        rs_val[i]    = pick();
        rt_val[i]    = pick();
        wdata[i]     = $urandom;
        mthi[i]      = ($urandom_range(0, 5) == 0);
        mtlo[i]      = ($urandom_range(0, 5) == 0);
        if (op_valid[i] && rt_val[i] == 32'd0) begin
          mthi[i] = 1'b0;
          mtlo[i] = 1'b0;
        end
      end
      @(posedge clock); #2;
      reset = 1'b0;
      clearInputs(i);
      repeat (10) @(posedge clock);
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
